vsi_op_queue: RTL and testbench

- Instruction buffer directly upstream of the coprocessor control FSM.
- Accepts ops from the host/driver over a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Presents them to the control FSM's vsi_op_valid/vsi_op_ready interface, so the host can issue back-to-back while the FSM spends 3 cycles per op.
- Also provides a combined idle indication (queue empty and FSM idle) for the driver.

---
 rtl/vsi_op_queue.sv | 100 ++++++++++
 tb/tb_vsi_op_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsi_op_queue.sv
// vsi_op_queue: DEPTH-entry op FIFO between the host driver and the coprocessor control FSM.
// Define VSI_OP_QUEUE_BYPASS_EN to pass the host op straight through when the queue is empty.
module vsi_op_queue #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             vsi_clk,
    input  logic             vsi_rst_n,
    input  logic             host_op_valid,
    output logic             host_op_ready,
    input  logic [31:0]      host_op,
    input  logic             host_lmul,
    input  logic             host_sew,
    output logic             vsi_op_valid,
    input  logic             vsi_op_ready,
    output logic [31:0]      vsi_op,
    output logic             vsi_lmul,
    output logic             vsi_sew,
    input  logic             vsi_cop_idle,
    input  logic             q_flush,
    output logic [PTR_W:0]   q_count,
    output logic             q_empty,
    output logic             q_full,
    output logic             vsi_all_idle
);
    localparam int CNT_W = PTR_W + 1;

    logic [33:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, full, byp, push, pop, wr_en, rd_en;
    logic [33:0]      head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

`ifdef VSI_OP_QUEUE_BYPASS_EN
    // Suppressed during flush so the FSM never consumes an op the host still holds.
    assign byp = empty & host_op_valid & ~q_flush;
`else
    assign byp = 1'b0;
`endif

    assign host_op_ready = ~full & ~q_flush;
    assign vsi_op_valid  = ~empty | byp;
    assign push          = host_op_valid & host_op_ready;
    assign pop           = vsi_op_valid & vsi_op_ready;
    assign wr_en         = push & ~(byp & vsi_op_ready);
    assign rd_en         = pop & ~byp;

    assign head = byp ? {host_sew, host_lmul, host_op} : mem_q[rd_ptr_q];
    assign {vsi_sew, vsi_lmul, vsi_op} = head;

    assign q_count      = count_q;
    assign q_empty      = empty;
    assign q_full       = full;
    assign vsi_all_idle = empty & vsi_cop_idle & ~host_op_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (q_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
        if (!vsi_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // wr_en is already low during flush, so storage keeps its stale contents.
    always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
        if (!vsi_rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= {host_sew, host_lmul, host_op};
        end
    end

endmodule

// File: tb/tb_vsi_op_queue.sv
// Self-checking bench for vsi_op_queue: directed steps plus random traffic against a queue-based model.
module tb_vsi_op_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic             vsi_clk = 1'b0;
    logic             vsi_rst_n = 1'b0;
    logic             host_op_valid = 1'b0;
    logic             host_op_ready;
    logic [31:0]      host_op = '0;
    logic             host_lmul = 1'b0;
    logic             host_sew = 1'b0;
    logic             vsi_op_valid;
    logic             vsi_op_ready = 1'b0;
    logic [31:0]      vsi_op;
    logic             vsi_lmul;
    logic             vsi_sew;
    logic             vsi_cop_idle = 1'b1;
    logic             q_flush = 1'b0;
    logic [PTR_W:0]   q_count;
    logic             q_empty;
    logic             q_full;
    logic             vsi_all_idle;

    logic [33:0] mdl_q[$];
    int checks = 0;
    int errors = 0;

    vsi_op_queue #(.DEPTH(DEPTH)) dut (
        .vsi_clk       (vsi_clk),
        .vsi_rst_n     (vsi_rst_n),
        .host_op_valid (host_op_valid),
        .host_op_ready (host_op_ready),
        .host_op       (host_op),
        .host_lmul     (host_lmul),
        .host_sew      (host_sew),
        .vsi_op_valid  (vsi_op_valid),
        .vsi_op_ready  (vsi_op_ready),
        .vsi_op        (vsi_op),
        .vsi_lmul      (vsi_lmul),
        .vsi_sew       (vsi_sew),
        .vsi_cop_idle  (vsi_cop_idle),
        .q_flush       (q_flush),
        .q_count       (q_count),
        .q_empty       (q_empty),
        .q_full        (q_full),
        .vsi_all_idle  (vsi_all_idle)
    );

    always #5 vsi_clk = ~vsi_clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic mdl_byp();
`ifdef VSI_OP_QUEUE_BYPASS_EN
        return (mdl_q.size() == 0) && host_op_valid && !q_flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 34'(vsi_op_valid), 34'(0));
        chk({tag, "_op"}, 34'({vsi_sew, vsi_lmul, vsi_op}), 34'(0));
        chk({tag, "_ready"}, 34'(host_op_ready), 34'(1));
        chk({tag, "_empty"}, 34'(q_empty), 34'(1));
        chk({tag, "_full"}, 34'(q_full), 34'(0));
        chk({tag, "_count"}, 34'(q_count), 34'(0));
    endtask

    task automatic check_outputs();
        logic byp;
        logic exp_valid;
        logic [33:0] exp_pl;
        byp = mdl_byp();
        exp_valid = (mdl_q.size() != 0) || byp;
        chk("q_count", 34'(q_count), 34'(mdl_q.size()));
        chk("count_le_depth", 34'(q_count <= DEPTH), 34'(1));
        chk("vsi_op_valid", 34'(vsi_op_valid), 34'(exp_valid));
        chk("host_op_ready", 34'(host_op_ready), 34'((mdl_q.size() < DEPTH) && !q_flush));
        chk("q_empty", 34'(q_empty), 34'(mdl_q.size() == 0));
        chk("q_full", 34'(q_full), 34'(mdl_q.size() == DEPTH));
        chk("vsi_all_idle", 34'(vsi_all_idle),
            34'((mdl_q.size() == 0) && vsi_cop_idle && !host_op_valid));
        if (exp_valid) begin
            exp_pl = byp ? {host_sew, host_lmul, host_op} : mdl_q[0];
            chk("head_payload", {vsi_sew, vsi_lmul, vsi_op}, exp_pl);
        end
    endtask

    // Checks outputs mid-cycle, then advances the model across the next rising edge.
    task automatic cycle();
        logic byp;
        logic do_push;
        logic [33:0] hp;
        @(negedge vsi_clk);
        check_outputs();
        byp = mdl_byp();
        hp = {host_sew, host_lmul, host_op};
        do_push = host_op_valid && (mdl_q.size() < DEPTH);
        @(posedge vsi_clk);
        if (q_flush) begin
            mdl_q.delete();
        end else if (byp) begin
            if (!vsi_op_ready) mdl_q.push_back(hp);
        end else begin
            if (mdl_q.size() != 0 && vsi_op_ready) void'(mdl_q.pop_front());
            if (do_push) mdl_q.push_back(hp);
        end
        #1;
    endtask

    initial begin
        int sent;
        int delivered;
        int k;
        logic acc;

        // reset and idle
        #1;
        check_reset_outputs("rst");
        #11;
        vsi_rst_n = 1'b1;
        cycle();
        cycle();
        chk("idle_all_idle", 34'(vsi_all_idle), 34'(1));

        // single push, payload holds while FSM is busy
        host_op = 32'h0000_1057; host_lmul = 1'b1; host_sew = 1'b0; host_op_valid = 1'b1;
        cycle();
        host_op_valid = 1'b0; host_op = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_op", 34'({vsi_sew, vsi_lmul, vsi_op}), {1'b0, 1'b1, 32'h0000_1057});
            chk("hold_valid", 34'(vsi_op_valid), 34'(1));
            cycle();
        end
        vsi_op_ready = 1'b1;
        cycle();
        vsi_op_ready = 1'b0;

        // fill to full, E held off, then drain
        for (int i = 0; i < 4; i++) begin
            host_op = 32'hA0 + 32'(i); host_lmul = i[0]; host_sew = i[1]; host_op_valid = 1'b1;
            cycle();
        end
        host_op = 32'hE0; host_lmul = 1'b0; host_sew = 1'b1;
        chk("full_flag", 34'(q_full), 34'(1));
        chk("full_ready", 34'(host_op_ready), 34'(0));
        cycle();
        cycle();
        vsi_op_ready = 1'b1;
        cycle();
        chk("e_ready_after_pop", 34'(host_op_ready), 34'(1));
        cycle();
        host_op_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("drained", 34'(q_count), 34'(0));
        vsi_op_ready = 1'b0;

        // stream 10 ops with FSM ready pattern 1,0,0
        sent = 0; delivered = 0; k = 0;
        host_op = $urandom; host_lmul = 1'($urandom); host_sew = 1'($urandom); host_op_valid = 1'b1;
        while ((sent < 10 || mdl_q.size() != 0) && k < 80) begin
            vsi_op_ready = (k % 3 == 0);
            #1;
            acc = host_op_valid && host_op_ready;
            if (vsi_op_valid && vsi_op_ready) delivered++;
            cycle();
            if (acc) begin
                sent++;
                if (sent < 10) begin
                    host_op = $urandom; host_lmul = 1'($urandom); host_sew = 1'($urandom);
                end else begin
                    host_op_valid = 1'b0;
                end
            end
            k++;
        end
        chk("stream_sent", 34'(sent), 34'(10));
        chk("stream_delivered", 34'(delivered), 34'(10));
        vsi_op_ready = 1'b0;

        // flush with a simultaneous push
        for (int i = 0; i < 3; i++) begin
            host_op = 32'hF00 + 32'(i); host_op_valid = 1'b1;
            cycle();
        end
        host_op = 32'hBAD0_0BAD; q_flush = 1'b1;
        cycle();
        q_flush = 1'b0; host_op_valid = 1'b0;
        chk("flush_count", 34'(q_count), 34'(0));
        chk("flush_valid", 34'(vsi_op_valid), 34'(0));
        cycle();
        host_op = 32'h0000_0777; host_lmul = 1'b0; host_sew = 1'b0; host_op_valid = 1'b1;
        cycle();
        host_op_valid = 1'b0;
        chk("post_flush_head", 34'(vsi_op), 34'(32'h0000_0777));
        vsi_op_ready = 1'b1;
        cycle();
        vsi_op_ready = 1'b0;

        // empty queue, push with FSM ready
        host_op = 32'hDEAD_0001; host_lmul = 1'b0; host_sew = 1'b1;
        host_op_valid = 1'b1; vsi_op_ready = 1'b1;
        #1;
`ifdef VSI_OP_QUEUE_BYPASS_EN
        chk("byp_valid", 34'(vsi_op_valid), 34'(1));
        chk("byp_op", 34'(vsi_op), 34'(32'hDEAD_0001));
`else
        chk("nobyp_valid", 34'(vsi_op_valid), 34'(0));
`endif
        cycle();
        host_op_valid = 1'b0;
`ifdef VSI_OP_QUEUE_BYPASS_EN
        chk("byp_count", 34'(q_count), 34'(0));
`else
        chk("nobyp_count", 34'(q_count), 34'(1));
`endif
        cycle();
        cycle();
        vsi_op_ready = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            host_op_valid = ($urandom_range(0, 3) != 0);
            host_op = $urandom; host_lmul = 1'($urandom); host_sew = 1'($urandom);
            vsi_op_ready = ($urandom_range(0, 2) == 0);
            vsi_cop_idle = 1'($urandom);
            q_flush = ($urandom_range(0, 31) == 0);
            cycle();
        end
        q_flush = 1'b0; vsi_op_ready = 1'b0; vsi_cop_idle = 1'b1;

        // reset asserted mid-operation
        host_op_valid = 1'b1; host_op = 32'h1234_5678;
        cycle();
        cycle();
        host_op_valid = 1'b0;
        #2;
        vsi_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        mdl_q.delete();
        @(negedge vsi_clk);
        vsi_rst_n = 1'b1;
        @(posedge vsi_clk);
        #1;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
